// File: rtl/exp2_module.sv
`timescale 1ns/1ps
// exp2_module: iterative fixed-point 2^x antilog, one constant multiply per fractional bit.
// Optional build macro EXP_ROUND_EN: round-to-nearest in the iteration multiply and final right shift.
module exp2_module #(
    parameter int IN_W = 16,
    parameter int Q_L  = 11,
    parameter int Q_M  = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IN_W-1:0] log_in,
    input  logic            data_valid,
    output logic            busy,
    output logic [31:0]     exp_out,
    output logic            exp_valid
);
    localparam int NW = IN_W - Q_L;
    localparam int KW = $clog2(Q_L + 2);

    typedef enum logic [1:0] {IDLE, ITER, SCALE} state_t;

    function automatic logic [63:0] isqrt(input logic [127:0] v);
        logic [63:0] r;
        logic [63:0] t;
        r = '0;
        for (int b = 63; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if ({64'd0, t} * {64'd0, t} <= v) r = t;
        end
        return r;
    endfunction

    // 2^(2^-k) by repeated square roots in Q62, rounded to Q30
    function automatic logic [Q_L*32-1:0] gen_rom();
        logic [Q_L*32-1:0] rom;
        logic [63:0] x;
        rom = '0;
        x = isqrt(128'd2 << 124);
        for (int k = 0; k < Q_L; k++) begin
            rom[k*32 +: 32] = 32'((x + 64'h8000_0000) >> 32);
            x = isqrt({x, 64'd0} >> 2);
        end
        return rom;
    endfunction

    localparam logic [Q_L*32-1:0] ROM = gen_rom();

    state_t                state_q, state_d;
    logic [31:0]           m_q, m_d, out_q, out_d;
    logic [Q_L-1:0]        f_q, f_d;
    logic signed [NW-1:0]  n_q, n_d;
    logic [KW-1:0]         k_q, k_d;
    logic                  valid_q, valid_d;
    logic [31:0]           c_k, scaled;
    logic [63:0]           prod;
    logic [32:0]           rnd, shr;
    int                    s;
    logic                  sat;

    always_comb begin
        c_k = '0;
        for (int i = 0; i < Q_L; i++)
            if (k_q == KW'(i + 1)) c_k = ROM[i*32 +: 32];
`ifdef EXP_ROUND_EN
        prod = {32'd0, m_q} * {32'd0, c_k} + 64'h2000_0000;
`else
        prod = {32'd0, m_q} * {32'd0, c_k};
`endif
        s = (30 - Q_M) - int'(n_q);
        sat = int'(n_q) > 30 - Q_M;
`ifdef EXP_ROUND_EN
        rnd = (s[4:0] == 5'd0) ? 33'd0 : 33'd1 << (s[4:0] - 5'd1);
`else
        rnd = '0;
`endif
        shr = ({1'b0, m_q} + rnd) >> s[4:0];
        scaled = sat ? 32'h7FFF_FFFF : (s > 31) ? 32'd0 : (shr[32:31] != 2'b00) ? 32'h7FFF_FFFF : shr[31:0];
        state_d = state_q;
        m_d = m_q;
        f_d = f_q;
        n_d = n_q;
        k_d = k_q;
        out_d = out_q;
        valid_d = 1'b0;
        if (state_q == IDLE && data_valid) begin
            state_d = ITER;
            n_d = log_in[IN_W-1:Q_L];
            f_d = log_in[Q_L-1:0];
            m_d = 32'h4000_0000;
            k_d = KW'(1);
        end else if (state_q == ITER) begin
            m_d = f_q[Q_L-1] ? 32'(prod >> 30) : m_q;
            f_d = f_q << 1;
            k_d = k_q + KW'(1);
            state_d = (k_q == KW'(Q_L)) ? SCALE : ITER;
        end else if (state_q == SCALE) begin
            out_d = scaled;
            valid_d = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q <= '0;
            f_q <= '0;
            n_q <= '0;
            k_q <= '0;
            out_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q <= m_d;
            f_q <= f_d;
            n_q <= n_d;
            k_q <= k_d;
            out_q <= out_d;
            valid_q <= valid_d;
        end
    end

    assign busy = state_q != IDLE;
    assign exp_out = out_q;
    assign exp_valid = valid_q;
endmodule

// File: tb/tb_exp2_module.sv
`timescale 1ns/1ps
// tb_exp2_module: vector table, handshake/reset sequences and randomized checks against a 2^x model.
module tb_exp2_module;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] li16 = '0;
    logic [17:0] li18 = '0;
    logic dv16 = 1'b0, dv18 = 1'b0;
    logic bz16, bz18, ev16, ev18;
    logic [31:0] eo16, eo18;
    int tests = 0, failed = 0;
    longint unsigned ck [1:11];

`ifdef EXP_ROUND_EN
    localparam longint unsigned RND = 64'd1 << 29;
    localparam bit ROUND = 1'b1;
    localparam logic [31:0] HALF_EXP = 32'd46341;
`else
    localparam longint unsigned RND = 64'd0;
    localparam bit ROUND = 1'b0;
    localparam logic [31:0] HALF_EXP = 32'd46340;
`endif

    always #5 clk = ~clk;

    exp2_module d16 (.clk(clk), .rst_n(rst_n), .log_in(li16), .data_valid(dv16),
                     .busy(bz16), .exp_out(eo16), .exp_valid(ev16));
    exp2_module #(.IN_W(18)) d18 (.clk(clk), .rst_n(rst_n), .log_in(li18), .data_valid(dv18),
                     .busy(bz18), .exp_out(eo18), .exp_valid(ev18));

    typedef struct {
        int          x;
        logic [31:0] y;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // 2^x from its definition: integer/fractional split, one constant per fraction bit, then scale
    function automatic logic [31:0] model(input int x);
        int n, s, f;
        longint unsigned m, r;
        n = x >>> 11;
        f = x & 2047;
        m = 64'd1 << 30;
        for (int k = 1; k <= 11; k++)
            if (f[11-k]) m = (m * ck[k] + RND) >> 30;
        s = 15 - n;
        if (n > 15) return 32'h7FFF_FFFF;
        if (s >= 32) return 32'd0;
        r = (ROUND && s > 0) ? (m + (64'd1 << (s - 1))) >> s : m >> s;
        return (r > 64'h7FFF_FFFF) ? 32'h7FFF_FFFF : 32'(r);
    endfunction

    task automatic convert(input bit sel, input int x, output logic [31:0] res, output int lat, output logic bsy);
        @(negedge clk);
        if (sel) begin li18 = x[17:0]; dv18 = 1'b1; end
        else begin li16 = x[15:0]; dv16 = 1'b1; end
        @(posedge clk);
        #1;
        dv16 = 1'b0;
        dv18 = 1'b0;
        bsy = sel ? bz18 : bz16;
        lat = -1;
        res = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (sel ? ev18 : ev16) begin
                lat = i;
                res = sel ? eo18 : eo16;
                break;
            end
        end
    endtask

    initial begin
        vec_t vt [4];
        logic [31:0] res;
        logic bsy;
        int lat, pulses, gap, x;
        logic [15:0] r16;
        logic [17:0] r18;
        for (int k = 1; k <= 11; k++)
            ck[k] = longint'($rtoi((2.0 ** (2.0 ** (-real'(k)))) * 1073741824.0 + 0.5));
        vt[0] = '{0, 32'd32768};
        vt[1] = '{6144, 32'd262144};
        vt[2] = '{-2048, 32'd16384};
        vt[3] = '{1024, HALF_EXP};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_exp_out", eo16, 0);
        chk("rst_exp_valid", ev16, 0);
        chk("rst_busy", bz16, 0);
        chk("rst18_exp_out", eo18, 0);
        chk("rst18_busy", bz18, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", bz16, 0);

        for (int i = 0; i < 4; i++) begin
            convert(1'b0, vt[i].x, res, lat, bsy);
            chk($sformatf("vec%0d_value", i), res, vt[i].y);
            chk($sformatf("vec%0d_latency", i), lat, 12);
            chk($sformatf("vec%0d_busy", i), bsy, 1);
        end

        convert(1'b1, 32768, res, lat, bsy);
        chk("sat_value", res, 32'h7FFF_FFFF);
        chk("sat_latency", lat, 12);
        convert(1'b1, -34816, res, lat, bsy);
        chk("underflow_value", res, 0);
        chk("underflow_latency", lat, 12);

        @(negedge clk);
        li16 = 16'd6144;
        dv16 = 1'b1;
        @(posedge clk);
        #1 dv16 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        li16 = 16'd2048;
        dv16 = 1'b1;
        @(negedge clk);
        dv16 = 1'b0;
        pulses = 0;
        res = '0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (ev16) begin pulses++; res = eo16; end
        end
        chk("busy_ignore_pulses", pulses, 1);
        chk("busy_ignore_value", res, 262144);

        @(negedge clk);
        li16 = 16'd0;
        dv16 = 1'b1;
        @(posedge clk);
        #1 dv16 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (ev16) begin lat = i; res = eo16; break; end
        end
        chk("b2b_first_latency", lat, 12);
        chk("b2b_first_value", res, 32768);
        li16 = 16'd2048;
        dv16 = 1'b1;
        gap = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            dv16 = 1'b0;
            if (ev16) begin gap = i; res = eo16; break; end
        end
        chk("b2b_gap", gap, 13);
        chk("b2b_second_value", res, 65536);

        @(negedge clk);
        li16 = 16'd6144;
        dv16 = 1'b1;
        @(posedge clk);
        #1 dv16 = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", bz16, 0);
        chk("midrst_exp_out", eo16, 0);
        chk("midrst_exp_valid", ev16, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (ev16) pulses++;
        end
        chk("midrst_no_valid", pulses, 0);
        convert(1'b0, -2048, res, lat, bsy);
        chk("after_rst_value", res, 16384);
        chk("after_rst_latency", lat, 12);

        for (int i = 0; i < 200; i++) begin
            r16 = 16'($urandom);
            x = int'($signed(r16));
            convert(1'b0, x, res, lat, bsy);
            chk($sformatf("rand16 x=%0d", x), res, model(x));
        end
        for (int i = 0; i < 60; i++) begin
            r18 = 18'($urandom);
            x = int'($signed(r18));
            convert(1'b1, x, res, lat, bsy);
            chk($sformatf("rand18 x=%0d", x), res, model(x));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
